nonce_feeder: RTL and testbench

- Initiator and collector for the dummy hashing pipe (`dummy_pipe130`-class, fixed latency, one hash per clock).
- Accepts a work unit (midstate plus 512-bit data block) and drives one candidate per cycle into the pipe, inserting an incrementing nonce.
- Tracks each nonce and its work tag through a delay line matched to the pipe latency.
- Tests each returned hash against a mask and queues hits in a small FIFO with a valid/ready output.

---
 rtl/nonce_feeder_pkg.sv | 41 ++++
 rtl/gold_fifo.sv | 50 +++++
 rtl/nonce_feeder.sv | 115 +++++++++++
 tb/tb_nonce_feeder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_feeder_pkg.sv
// nonce_feeder_pkg: shared definitions for the nonce feeder.
//   IDX(w)        : part-select for 32-bit word w of a packed block
//   LATENCY_DEF   : default pipe latency, 1 + 2*PIPE_STAGES + 1
//   GOLD_W        : width of a golden record {nonce, tag}
//   state_t       : sweep FSM states
//   cand_t/gold_t : delay-line entry and golden record layouts
//   put_word      : returns a 512-bit block with one 32-bit word replaced
`ifndef NONCE_FEEDER_IDX
`define NONCE_FEEDER_IDX
`define IDX(w) ((w)*32) +: 32
`endif

package nonce_feeder_pkg;

  localparam int PIPE_STAGES = 32;
  localparam int LATENCY_DEF = 1 + 2*PIPE_STAGES + 1;
  localparam int GOLD_W      = 36;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] nonce;
    logic [3:0]  tag;
  } cand_t;

  typedef struct packed {
    logic [31:0] nonce;
    logic [3:0]  tag;
  } gold_t;

  function automatic logic [511:0] put_word(input logic [511:0] blk,
                                            input int w,
                                            input logic [31:0] v);
    logic [511:0] r;
    r = blk;
    r[`IDX(w)] = v;
    return r;
  endfunction

endpackage

// File: rtl/gold_fifo.sv
// gold_fifo: synchronous FIFO, registered pointers, no write-to-read bypass.
//   clk, rst_n : clock, async active-low reset
//   push/push_data : write request (accepted if not full, or full with pop)
//   pop/pop_data   : pop request (ignored when empty); pop_data is the head
//   full/empty     : status from an extra-MSB pointer compare
// DEPTH must be a power of two, >= 2.
module gold_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                  wr_ptr, rd_ptr;
  logic [DEPTH-1:0][WIDTH-1:0]  mem;
  logic                         do_push, do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full FIFO is legal when the head leaves in the same cycle:
  // the write lands in the slot being vacated.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/nonce_feeder.sv
// nonce_feeder: drives one candidate per clock into a fixed-latency hash pipe,
// tracks {nonce, tag} alongside it, and queues hits in a golden FIFO.
//   clk, rst_n            : clock, async active-low reset
//   work_valid/ready      : work handshake (ready is always 1, work preempts)
//   work_state/data/tag   : midstate, data block (start nonce in NONCE_WORD), id
//   pipe_state/pipe_data  : candidate to the pipe
//   pipe_hash             : pipe result, LATENCY clocks after pipe_data
//   gold_valid/ready      : golden FIFO head handshake
//   gold_nonce/gold_tag   : golden FIFO head
//   busy                  : sweep in progress
//   overflow              : sticky, a hit was dropped on a full FIFO
module nonce_feeder
  import nonce_feeder_pkg::*;
#(
  parameter int          LATENCY    = LATENCY_DEF,
  parameter int          NONCE_WORD = 3,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] HIT_MASK   = 32'hFFFF_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] work_state,
  input  logic [511:0] work_data,
  input  logic [3:0]   work_tag,
  output logic [255:0] pipe_state,
  output logic [511:0] pipe_data,
  input  logic [31:0]  pipe_hash,
  output logic         gold_valid,
  input  logic         gold_ready,
  output logic [31:0]  gold_nonce,
  output logic [3:0]   gold_tag,
  output logic         busy,
  output logic         overflow
);

  state_t       state;
  logic [255:0] ws_q;
  logic [511:0] wd_q;
  logic [3:0]   wt_q;
  logic [31:0]  cnt;
  cand_t        cand;   // issued alongside pipe_data, i.e. delay-line stage 0

  assign work_ready = 1'b1;
  assign busy       = (state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ws_q       <= '0;
      wd_q       <= '0;
      wt_q       <= '0;
      cnt        <= '0;
      cand       <= '0;
      pipe_state <= '0;
      pipe_data  <= '0;
    end else begin
      cand <= '0;
      if (work_valid) begin
        // Accept (also preempts a running sweep); nothing issued this cycle.
        ws_q  <= work_state;
        wd_q  <= work_data;
        wt_q  <= work_tag;
        cnt   <= work_data[`IDX(NONCE_WORD)];
        state <= S_RUN;
      end else if (state == S_RUN) begin
        pipe_state <= ws_q;
        pipe_data  <= put_word(wd_q, NONCE_WORD, cnt);
        cand       <= '{vld: 1'b1, nonce: cnt, tag: wt_q};
        // The all-ones nonce ends the sweep; the counter never wraps.
        if (cnt == '1) state <= S_IDLE;
        else           cnt   <= cnt + 32'd1;
      end
    end
  end

  // LATENCY entries behind the issue register: the oldest one lines up with
  // the pipe_hash of the same candidate.
  cand_t [LATENCY-1:0] dl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dl <= '0;
    else        dl <= {dl[LATENCY-2:0], cand};
  end

  logic  hit, fifo_full, fifo_empty;
  logic [GOLD_W-1:0] head;
  gold_t hd;

  assign hit = dl[LATENCY-1].vld && ((pipe_hash & HIT_MASK) == '0);

  gold_fifo #(.WIDTH(GOLD_W), .DEPTH(FIFO_DEPTH)) u_gold (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (hit),
    .push_data ({dl[LATENCY-1].nonce, dl[LATENCY-1].tag}),
    .pop       (gold_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign hd         = gold_t'(head);
  assign gold_valid = ~fifo_empty;
  assign gold_nonce = hd.nonce;
  assign gold_tag   = hd.tag;

  // Full implies non-empty, so gold_ready alone means a pop this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               overflow <= 1'b0;
    else if (hit && fifo_full && !gold_ready) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_nonce_feeder.sv
module tb_nonce_feeder;
  import nonce_feeder_pkg::*;

  localparam int LAT = 66;
  localparam logic [255:0] ST_PAT = {8{32'hCAFE_0001}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         work_valid = 1'b0;
  logic         work_ready;
  logic [255:0] work_state = '0;
  logic [511:0] work_data = '0;
  logic [3:0]   work_tag = '0;
  logic [255:0] pipe_state;
  logic [511:0] pipe_data;
  logic [31:0]  pipe_hash;
  logic         gold_valid;
  logic         gold_ready = 1'b0;
  logic [31:0]  gold_nonce;
  logic [3:0]   gold_tag;
  logic         busy;
  logic         overflow;

  always #5 clk = ~clk;

  nonce_feeder dut (
    .clk(clk), .rst_n(rst_n),
    .work_valid(work_valid), .work_ready(work_ready),
    .work_state(work_state), .work_data(work_data), .work_tag(work_tag),
    .pipe_state(pipe_state), .pipe_data(pipe_data), .pipe_hash(pipe_hash),
    .gold_valid(gold_valid), .gold_ready(gold_ready),
    .gold_nonce(gold_nonce), .gold_tag(gold_tag),
    .busy(busy), .overflow(overflow)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pipe model: LAT registers on the nonce word; hash zero for listed nonces.
  logic [31:0] p [LAT] = '{default: 32'h0};
  logic [31:0] hit_list [8];
  int          hit_cnt = 0;
  bit          force_zero = 1'b0;

  always @(posedge clk) begin
    p[0] <= pipe_data[127:96];
    for (int i = 1; i < LAT; i++) p[i] <= p[i-1];
  end

  always_comb begin
    pipe_hash = p[LAT-1] ^ 32'h1234_0000;
    if (force_zero) pipe_hash = '0;
    for (int i = 0; i < 8; i++)
      if (i < hit_cnt && p[LAT-1] == hit_list[i]) pipe_hash = '0;
  end

  int    checks = 0, errors = 0;
  gold_t expq [$];
  bit    saw_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    gold_t e;
    forever begin
      @(negedge clk);
      if (gold_valid) saw_valid = 1'b1;
      if (rst_n && gold_valid && gold_ready) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL gold_unexpected actual %0h/%0h required none", gold_nonce, gold_tag);
        end else begin
          e = expq.pop_front();
          check("gold_pop", {28'h0, gold_nonce, gold_tag}, {28'h0, e.nonce, e.tag});
        end
      end
    end
  endtask

  task automatic set_hits(input int n, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d, input logic [31:0] e,
                          input logic [31:0] f);
    hit_list[0] = a; hit_list[1] = b; hit_list[2] = c;
    hit_list[3] = d; hit_list[4] = e; hit_list[5] = f;
    hit_cnt = n;
  endtask

  task automatic expect_gold(input logic [31:0] n, input logic [3:0] t);
    expq.push_back('{nonce: n, tag: t});
  endtask

  // Called just after a posedge; returns just after the accept edge.
  task automatic send_work(input logic [3:0] tag, input logic [31:0] start);
    for (int i = 0; i < 16; i++) work_data[i*32 +: 32] = 32'hD000_0000 + i;
    work_data[127:96] = start;
    work_state = ST_PAT;
    work_tag   = tag;
    work_valid = 1'b1;
    @(posedge clk); #1;
    work_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int maxc);
    for (int i = 0; i < maxc && expq.size() != 0; i++) @(negedge clk);
    check(name, expq.size(), 0);
  endtask

  task automatic wait_nonce(input string name, input logic [31:0] n, output int c);
    bit found = 1'b0;
    c = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (busy && pipe_data[127:96] == n) begin found = 1'b1; c = cyc; end
    end
    check(name, found, 1);
  endtask

  initial begin
    int c0, c1, bcnt;
    bit got;
    fork monitor(); join_none

    // Reset and idle.
    repeat (3) @(posedge clk);
    #1;
    check("rst_work_ready", work_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_gold_valid", gold_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_pipe_data_zero", pipe_data == '0, 1);
    check("rst_gold_nonce", {gold_nonce, gold_tag}, 0);
    rst_n = 1'b1;
    gold_ready = 1'b1;
    force_zero = 1'b1;
    saw_valid = 1'b0;
    repeat (200) @(posedge clk);
    #1 check("idle_no_hit", saw_valid, 0);
    force_zero = 1'b0;

    // Basic sweep from 0x10, only 0x15 hits.
    set_hits(1, 32'h15, 0, 0, 0, 0, 0);
    expect_gold(32'h15, 4'h5);
    send_work(4'h5, 32'h10);
    @(posedge clk); #1;
    check("first_nonce", pipe_data[127:96], 32'h10);
    check("pipe_word0", pipe_data[31:0], 32'hD000_0000);
    check("pipe_state", pipe_state == ST_PAT, 1);
    check("busy_run", busy, 1);
    wait_nonce("find_0x15", 32'h15, c0);
    got = 1'b0; c1 = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (gold_valid) begin got = 1'b1; c1 = cyc; end
    end
    check("hit_latency", c1 - c0, LAT + 1);
    wait_drain("drain_basic", 20);

    // Reset mid-sweep: in-flight candidates vanish.
    set_hits(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    send_work(4'h6, 32'h500);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    force_zero = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    saw_valid = 1'b0;
    check("midrst_busy", busy, 0);
    repeat (150) @(posedge clk);
    #1 check("midrst_no_hit", saw_valid, 0);
    force_zero = 1'b0;

    // End of range: FD, FE, FF then stop, no wrap to 0.
    set_hits(4, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 0, 0);
    expect_gold(32'hFFFF_FFFD, 4'h3);
    expect_gold(32'hFFFF_FFFE, 4'h3);
    expect_gold(32'hFFFF_FFFF, 4'h3);
    send_work(4'h3, 32'hFFFF_FFFD);
    bcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    check("eor_busy_cycles", bcnt, 3);
    check("eor_no_wrap", pipe_data[127:96], 32'hFFFF_FFFF);
    wait_drain("drain_eor", 100);
    repeat (80) @(posedge clk);
    #1;
    do_reset();

    // Preemption at cycle 10.
    set_hits(5, 32'h103, 32'h108, 32'h109, 32'h201, 32'h204, 0);
    expect_gold(32'h103, 4'h1);
    expect_gold(32'h108, 4'h1);
    expect_gold(32'h201, 4'h2);
    expect_gold(32'h204, 4'h2);
    send_work(4'h1, 32'h100);
    repeat (9) @(posedge clk);
    #1 send_work(4'h2, 32'h200);
    wait_drain("drain_preempt", 150);
    repeat (10) @(posedge clk);
    #1 do_reset();

    // FIFO full: six hits, four held, overflow set.
    gold_ready = 1'b0;
    set_hits(6, 32'h300, 32'h301, 32'h302, 32'h303, 32'h304, 32'h305);
    for (int i = 0; i < 4; i++) expect_gold(32'h300 + i, 4'h7);
    send_work(4'h7, 32'h300);
    for (int i = 0; i < 150 && !overflow; i++) @(negedge clk);
    check("full_overflow", overflow, 1);
    check("full_head", {gold_valid, gold_nonce, gold_tag}, {1'b1, 32'h300, 4'h7});
    repeat (5) @(posedge clk);
    #1 check("full_head_stable", gold_nonce, 32'h300);
    gold_ready = 1'b1;
    wait_drain("drain_full", 20);
    repeat (2) @(posedge clk);
    #1 check("full_empty_after", gold_valid, 0);
    do_reset();

    // Push and pop together on a full FIFO.
    gold_ready = 1'b0;
    set_hits(5, 32'h400, 32'h401, 32'h402, 32'h403, 32'h40A, 0);
    for (int i = 0; i < 4; i++) expect_gold(32'h400 + i, 4'h8);
    expect_gold(32'h40A, 4'h8);
    send_work(4'h8, 32'h400);
    wait_nonce("find_0x40a", 32'h40A, c0);
    repeat (LAT) @(posedge clk);
    #1 gold_ready = 1'b1;
    @(posedge clk);
    #1 gold_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pp_overflow", overflow, 0);
    check("pp_head", {gold_valid, gold_nonce}, {1'b1, 32'h401});
    check("pp_left", expq.size(), 4);
    gold_ready = 1'b1;
    wait_drain("drain_pp", 20);
    repeat (2) @(posedge clk);
    #1 check("pp_empty_after", gold_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
